// File: rtl/multi_edge_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : edge_detect_pkg
//  Description: Shared types and default constants for the multi-channel
//               filtered edge detector.
//  Revision   : 1.0 - initial release
// ============================================================================
package edge_detect_pkg;

  // Per-channel edge qualification mode
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Default parameter values shared by the interface, top and channel
  localparam int   c_default_channels      = 4;
  localparam int   c_default_sync_stages   = 2;
  localparam int   c_default_filter_cycles = 3;
  localparam logic c_default_init_level    = 1'b0;

  // True when a filtered-level transition to new_level is reportable under mode.
  // A transition to 1 is a rising edge, a transition to 0 is a falling edge.
  function automatic logic edge_qualifies(input edge_mode_t mode, input logic new_level);
    logic result;
    result = 1'b0;
    case (mode)
      EDGE_OFF:  result = 1'b0;
      EDGE_RISE: result = new_level;
      EDGE_FALL: result = ~new_level;
      EDGE_BOTH: result = 1'b1;
      default:   result = 1'b0;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_edge_detect_if.sv
`default_nettype none
// ============================================================================
//  Interface  : multi_edge_detect_if
//  Description: Control/status bundle of the multi-channel edge detector.
//               The master side drives the raw inputs and configuration;
//               the slave side (the detector) returns levels, strobes and
//               sticky flags.
//  Revision   : 1.0 - initial release
// ============================================================================
interface multi_edge_detect_if #(
  parameter int CHANNELS = edge_detect_pkg::c_default_channels
);

  logic [CHANNELS-1:0]   signal_in;   // raw asynchronous inputs
  logic [2*CHANNELS-1:0] mode;        // edge_mode_t per channel, 2 bits each
  logic [CHANNELS-1:0]   irq_enable;  // per-channel interrupt mask
  logic [CHANNELS-1:0]   clear;       // write-1-to-clear for pending
  logic [CHANNELS-1:0]   level;       // filtered level
  logic [CHANNELS-1:0]   edge_pulse;  // one-cycle qualified edge strobe
  logic [CHANNELS-1:0]   pending;     // sticky edge flags
  logic                  irq;         // OR of enabled pending flags

  modport master (
    output signal_in,
    output mode,
    output irq_enable,
    output clear,
    input  level,
    input  edge_pulse,
    input  pending,
    input  irq
  );

  modport slave (
    input  signal_in,
    input  mode,
    input  irq_enable,
    input  clear,
    output level,
    output edge_pulse,
    output pending,
    output irq
  );

endinterface
`default_nettype wire

// File: rtl/multi_edge_detect_channel.sv
`default_nettype none
// ============================================================================
//  Module     : edge_filter_channel
//  Description: One detector channel: input synchroniser, persistence
//               filter, mode-qualified edge strobe and sticky pending flag.
//  Revision   : 1.0 - initial release
// ============================================================================
module edge_filter_channel
  import edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES   = c_default_sync_stages,
  parameter int   FILTER_CYCLES = c_default_filter_cycles,
  parameter logic INIT_LEVEL    = c_default_init_level
) (
  input  wire logic       clock,
  input  wire logic       reset_n,
  input  wire logic       i_signal,
  input  wire logic [1:0] i_mode,
  input  wire logic       i_clear,
  output logic            o_level,
  output logic            o_edge_pulse,
  output logic            o_pending
);

  // The counter only has to reach FILTER_CYCLES-1; one spare bit keeps the
  // width legal when FILTER_CYCLES is 1.
  localparam int              CNT_W      = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_edge_pulse;
  logic                   r_pending;

  edge_mode_t w_mode;
  logic       w_sample;     // synchronised sample
  logic       w_differs;    // sample disagrees with the accepted level
  logic       w_accept;     // new level has persisted long enough
  logic       w_qualified;  // accepted transition is reportable in this mode

  assign w_mode      = edge_mode_t'(i_mode);
  assign w_sample    = r_sync[SYNC_STAGES-1];
  assign w_differs   = (w_sample != r_level);
  assign w_accept    = w_differs && (r_cnt == c_cnt_last);
  // The direction of the transition is the value being accepted.
  assign w_qualified = w_accept && edge_qualifies(w_mode, w_sample);

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};
    end
  end

  // Persistence filter: any return to the current level restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= INIT_LEVEL;
    end else if (!w_differs) begin
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_level <= w_sample;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + c_cnt_one;
    end
  end

  // Registered strobe, aligned with the level update it reports.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_pulse <= 1'b0;
    end else begin
      r_edge_pulse <= w_qualified;
    end
  end

  // Sticky flag; a new event wins over a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_qualified | (r_pending & ~i_clear);
    end
  end

  assign o_level      = r_level;
  assign o_edge_pulse = r_edge_pulse;
  assign o_pending    = r_pending;

endmodule
`default_nettype wire

// File: rtl/multi_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module     : multi_edge_detect
//  Description: CHANNELS independent filtered edge detectors with per-channel
//               mode, sticky pending flags and a single masked interrupt.
//  Revision   : 1.0 - initial release
// ============================================================================
module multi_edge_detect
  import edge_detect_pkg::*;
#(
  parameter int   CHANNELS      = c_default_channels,
  parameter int   SYNC_STAGES   = c_default_sync_stages,
  parameter int   FILTER_CYCLES = c_default_filter_cycles,
  parameter logic INIT_LEVEL    = c_default_init_level
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  multi_edge_detect_if.slave bus
);

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_edge_pulse;
  logic [CHANNELS-1:0] w_pending;

  // One self-contained detector per input channel.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
    edge_filter_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .INIT_LEVEL    (INIT_LEVEL)
    ) u_channel (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_signal     (bus.signal_in[gi]),
      .i_mode       (bus.mode[2*gi+1 -: 2]),
      .i_clear      (bus.clear[gi]),
      .o_level      (w_level[gi]),
      .o_edge_pulse (w_edge_pulse[gi]),
      .o_pending    (w_pending[gi])
    );
  end

  assign bus.level      = w_level;
  assign bus.edge_pulse = w_edge_pulse;
  assign bus.pending    = w_pending;

  // Interrupt is combinational so mask changes take effect immediately.
  assign bus.irq = |(w_pending & bus.irq_enable);

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module     : tb_multi_edge_detect
//  Description: Self-checking bench for multi_edge_detect. Two instances:
//               defaults (4 ch, filter 3) and 8 ch with filter 1.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_multi_edge_detect;
  import edge_detect_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  multi_edge_detect_if #(.CHANNELS(4)) bus_a ();
  multi_edge_detect_if #(.CHANNELS(8)) bus_b ();

  multi_edge_detect #(
    .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .INIT_LEVEL(1'b0)
  ) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  multi_edge_detect #(
    .CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(1), .INIT_LEVEL(1'b0)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  typedef struct packed {
    logic        dut_b;
    logic [7:0]  sig;
    logic [15:0] mode;
    logic [7:0]  ie;
    logic [7:0]  clr;
    logic [7:0]  lvl;
    logic [7:0]  pls;
    logic [7:0]  pnd;
    logic        irq;
  } vec_t;

  typedef struct packed {
    logic       dut_b;
    logic [7:0] lvl;
    logic [7:0] pls;
    logic [7:0] pnd;
    logic       irq;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // ch3 OFF, ch2 FALL, ch1 BOTH, ch0 RISE; then ch3 switched to BOTH
  logic [15:0] m1 = {8'h00, EDGE_OFF, EDGE_FALL, EDGE_BOTH, EDGE_RISE};
  logic [15:0] m2 = {8'h00, EDGE_BOTH, EDGE_FALL, EDGE_BOTH, EDGE_RISE};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void addn(input int n, input logic b, input logic [7:0] sig,
                               input logic [15:0] md, input logic [7:0] ie,
                               input logic [7:0] clr, input logic [7:0] lvl,
                               input logic [7:0] pls, input logic [7:0] pnd,
                               input logic irq);
    vec_t v;
    v.dut_b = b; v.sig = sig; v.mode = md; v.ie = ie; v.clr = clr;
    v.lvl = lvl; v.pls = pls; v.pnd = pnd; v.irq = irq;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    if (v.dut_b) begin
      bus_b.signal_in  = v.sig;
      bus_b.mode       = v.mode;
      bus_b.irq_enable = v.ie;
      bus_b.clear      = v.clr;
    end else begin
      bus_a.signal_in  = v.sig[3:0];
      bus_a.mode       = v.mode[7:0];
      bus_a.irq_enable = v.ie[3:0];
      bus_a.clear      = v.clr[3:0];
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    logic [7:0] lvl, pls, pnd;
    logic       irq;
    if (e.dut_b) begin
      lvl = bus_b.level; pls = bus_b.edge_pulse; pnd = bus_b.pending; irq = bus_b.irq;
    end else begin
      lvl = {4'h0, bus_a.level}; pls = {4'h0, bus_a.edge_pulse};
      pnd = {4'h0, bus_a.pending}; irq = bus_a.irq;
    end
    check({tag, " level"},      lvl, e.lvl);
    check({tag, " edge_pulse"}, pls, e.pls);
    check({tag, " pending"},    pnd, e.pnd);
    check({tag, " irq"},        {7'h0, irq}, {7'h0, e.irq});
  endtask

  task automatic run_table(input string tag);
    vec_t v;
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clock);
      drive(v);
      e.dut_b = v.dut_b; e.lvl = v.lvl; e.pls = v.pls; e.pnd = v.pnd; e.irq = v.irq;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      compare_outputs($sformatf("%s[%0d]", tag, i), e);
      bus_a.clear = '0;
      bus_b.clear = '0;
    end
    tbl.delete();
  endtask

  initial begin
    exp_t z;
    z = '0;
    bus_a.signal_in = '0; bus_a.mode = m1[7:0]; bus_a.irq_enable = 4'h1; bus_a.clear = '0;
    bus_b.signal_in = '0; bus_b.mode = 16'hFFFF; bus_b.irq_enable = 8'hFF; bus_b.clear = '0;

    // Reset state on both instances
    repeat (2) @(posedge clock);
    #1;
    compare_outputs("reset_a", z);
    z.dut_b = 1'b1;
    compare_outputs("reset_b", z);
    @(negedge clock);
    reset_n = 1'b1;

    // Phase 1: rise on ch0, glitch on ch1, pulse on ch2/ch3, clear vs set
    addn(1, 0, 8'h01, m1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addn(2, 0, 8'h03, m1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addn(1, 0, 8'h01, m1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addn(1, 0, 8'h01, m1, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 1);
    addn(5, 0, 8'h01, m1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 1);
    addn(4, 0, 8'h0D, m1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 1);
    addn(4, 0, 8'h0D, m1, 8'h01, 8'h00, 8'h0D, 8'h00, 8'h01, 1);
    addn(4, 0, 8'h01, m1, 8'h01, 8'h00, 8'h0D, 8'h00, 8'h01, 1);
    addn(1, 0, 8'h01, m1, 8'h01, 8'h00, 8'h01, 8'h04, 8'h05, 1);
    addn(3, 0, 8'h01, m1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h05, 1);
    addn(4, 0, 8'h00, m1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h05, 1);
    addn(1, 0, 8'h00, m1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 1);
    addn(4, 0, 8'h01, m1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 1);
    addn(1, 0, 8'h01, m1, 8'h01, 8'h01, 8'h01, 8'h01, 8'h05, 1);
    addn(1, 0, 8'h01, m1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h05, 1);
    addn(1, 0, 8'h01, m1, 8'h01, 8'h01, 8'h01, 8'h00, 8'h04, 0);
    addn(2, 0, 8'h01, m1, 8'h04, 8'h00, 8'h01, 8'h00, 8'h04, 1);
    addn(1, 0, 8'h01, m2, 8'h04, 8'h00, 8'h01, 8'h00, 8'h04, 1);
    // ch1 rises and is held for four edges: its filter count reaches 2
    addn(4, 0, 8'h03, m2, 8'h04, 8'h00, 8'h01, 8'h00, 8'h04, 1);
    run_table("p1");

    // Reset mid-filter: outputs clear at once, aborted transition stays silent
    @(negedge clock);
    bus_a.signal_in = '0;
    reset_n = 1'b0;
    #1;
    z = '0;
    compare_outputs("rst_now", z);
    @(posedge clock);
    #1;
    compare_outputs("rst_held", z);
    @(negedge clock);
    reset_n = 1'b1;

    addn(4, 0, 8'h00, m2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addn(4, 0, 8'h02, m2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addn(1, 0, 8'h02, m2, 8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 0);
    addn(1, 0, 8'h02, m2, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 0);
    run_table("p2");

    // irq follows irq_enable without waiting for a clock edge
    @(negedge clock);
    bus_a.irq_enable = 4'h2;
    #1;
    check("irq_en_on irq", {7'h0, bus_a.irq}, 8'h01);
    check("irq_en_on pending", {4'h0, bus_a.pending}, 8'h02);
    @(negedge clock);
    bus_a.irq_enable = 4'h0;
    #1;
    check("irq_en_off irq", {7'h0, bus_a.irq}, 8'h00);
    check("irq_en_off pending", {4'h0, bus_a.pending}, 8'h02);

    // Phase 3: 8 channels, filter 1, all toggled together
    addn(2, 1, 8'hFF, 16'hFFFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addn(1, 1, 8'hFF, 16'hFFFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1);
    addn(1, 1, 8'hFF, 16'hFFFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 1);
    addn(2, 1, 8'h00, 16'hFFFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 1);
    addn(1, 1, 8'h00, 16'hFFFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 1);
    addn(1, 1, 8'h00, 16'hFFFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    run_table("p3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_edge_detect.md
MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel, range 2..4.
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 3: consecutive cycles a changed level must persist before acceptance, range 1..255.
REQ-004 The block SHALL have parameter INIT_LEVEL, default 1'b0: reset value of every synchroniser and filtered-level flop.
REQ-005 The block SHALL have port clock, input, 1: single clock for all logic.
REQ-006 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port signal_in, input, CHANNELS: raw asynchronous inputs.
REQ-008 The block SHALL have port mode, input, 2*CHANNELS: per-channel edge_mode_t; bits [2i+1:2i] belong to channel i.
REQ-009 The block SHALL have port irq_enable, input, CHANNELS: per-channel mask for irq.
REQ-010 The block SHALL have port clear, input, CHANNELS: write-1-to-clear strobe for pending.
REQ-011 The block SHALL have port level, output, CHANNELS: filtered level.
REQ-012 The block SHALL have port edge_pulse, output, CHANNELS: one-cycle detected-edge strobe.
REQ-013 The block SHALL have port pending, output, CHANNELS: sticky edge flags.
REQ-014 The block SHALL have port irq, output, 1: OR of (pending & irq_enable).

Function
REQ-015 Each channel SHALL pass signal_in[i] through SYNC_STAGES flops; the last stage is the synchronised sample s.
REQ-016 The filter SHALL run per channel with counter cnt (width clog2(FILTER_CYCLES)+1) and the following per-edge priority:
- s==level: cnt<=0.
- s!=level and cnt==FILTER_CYCLES-1: level<=s, cnt<=0.
- otherwise: cnt<=cnt+1.
REQ-017 A glitch shorter than FILTER_CYCLES synchronised cycles SHALL NOT change level and SHALL produce no edge_pulse.
REQ-018 For an input change first sampled at edge k and held stable, level SHALL update at edge k+SYNC_STAGES+FILTER_CYCLES-1 (defaults: 5 edges inclusive of k).
REQ-019 edge_pulse[i] SHALL be a registered output, high for exactly one cycle after the edge at which level[i] changes, qualified by mode[i] as sampled at that edge:
- OFF (00): never.
- RISE (01): 0->1 only.
- FALL (10): 1->0 only.
- BOTH (11): either direction.
REQ-020 pending[i] SHALL set at the edge where edge_pulse[i] is produced and clear at an edge where clear[i]=1.
REQ-021 If set and clear coincide on the same edge, pending[i] SHALL end set.
REQ-022 Setting pending[i] while already set SHALL have no further effect; no event count is kept.
REQ-023 irq SHALL be combinational: irq = OR over i of (pending[i] & irq_enable[i]).
REQ-024 A mode change SHALL affect only transitions occurring at or after the edge the new value is sampled; it SHALL NOT clear pending or alter level.
REQ-025 irq_enable changes SHALL affect irq in the same cycle and SHALL NOT modify pending.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-027 While reset_n=0, and immediately on its falling edge, all state SHALL take reset values:
- sync flops and level: INIT_LEVEL.
- cnt: 0.
- edge_pulse and pending: 0.
- irq: 0.
REQ-028 Reset asserted mid-filter SHALL abort any partial count; no edge_pulse SHALL be produced for the aborted transition.
REQ-029 After reset release, an input differing from INIT_LEVEL SHALL be treated as a normal transition (latency per REQ-018).

Structure
REQ-030 Package edge_detect_pkg SHALL hold:
- typedef edge_mode_t (2-bit enum: EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH).
- the default parameter constants.
REQ-031 Per-channel synchroniser, filter, edge qualification and pending flop SHALL be one sub-module, edge_filter_channel, instantiated CHANNELS times by a generate loop; irq aggregation stays in the top.

Verification
REQ-032 Defaults, ch0 RISE, signal_in[0] 0->1 held 10 cycles -> level[0]=1 and edge_pulse[0]=1 for one cycle 5 edges after the first sampling edge; pending[0]=1; irq=1 when irq_enable[0]=1.
REQ-033 Defaults, ch1 BOTH, 2-cycle-wide high glitch on signal_in[1] -> no level change, no edge_pulse, pending[1] stays 0.
REQ-034 ch2 FALL, input 0->1->0, each level held 8 cycles -> exactly one edge_pulse[2] (the 1->0); ch3 OFF given the same stimulus -> no pulse, but level[3] follows the input.
REQ-035 pending[0]=1, then clear[0]=1 on the same edge a new edge_pulse[0] is produced -> pending[0]=1 afterwards; clear alone on a later edge -> pending[0]=0 and irq=0.
REQ-036 reset_n pulsed low during an in-progress filter count (cnt=2) -> level, pending and edge_pulse read 0 immediately; no pulse after release if the input has returned to 0.
REQ-037 CHANNELS=8, FILTER_CYCLES=1, all channels BOTH, all inputs toggled together -> all 8 edge_pulse bits high in the same cycle, 2 edges after the first sampling edge.
